regfile_write_sequencer: RTL

- Requester-side counterpart of the CPU register file's single write port.
- Merges register-write requests from two producers into one registered write stream:
  - port A: pipeline writeback;
  - port B: long-latency unit, e.g. load return or mul/div.
- Drives RegWrite/Write_register/Write_data into the register file.
- Keeps a per-register pending-write scoreboard that issue logic queries for RAW stalls.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/regfile_write_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file write definitions.
//   REG_W / DATA_W   register address and data widths
//   wb_req_t         one queued write request {rd, data}
//   ZERO_REG         hard-wired zero register ($0), never written
//   is_zero_reg()    helper used wherever $0 writes must be dropped
package cpu_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << REG_W;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
    return r == ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t write requests.
//   clk, reset        clock, asynchronous active-high reset (empties FIFO)
//   push, push_data   enqueue request; ignored when full (pre-edge occupancy)
//   pop, pop_data     dequeue head; pop_data is the current head (show-ahead)
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally modulo DEPTH.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_req_t                  push_data,
  input  logic                     pop,
  output wb_req_t                  pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Full is judged on the pre-edge occupancy: a simultaneous pop does not
  // make room for a push in the same cycle.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer: merges two write-request ports into the register
// file's single write port and tracks outstanding writes per register.
//   clk, reset                      clock, asynchronous active-high reset
//   a_valid/a_ready/a_reg/a_data    port A (pipeline writeback) request
//   b_valid/b_ready/b_reg/b_data    port B (long-latency unit) request
//   rsv_valid/rsv_ready/rsv_reg     issue-side destination reservation
//   chk_reg1/2 -> chk_busy1/2       combinational pending-write queries
//   RegWrite/Write_register/Write_data  registered register-file write port
//   fifo_count                      request FIFO occupancy
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. ready is combinational from the current state and the other
// port's valid; at most one of A/B transfers per edge. A request to $0
// completes its handshake but is discarded.
module regfile_write_sequencer
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int STARVE = 3,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [REG_W-1:0]        a_reg,
  input  logic [DATA_W-1:0]       a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [REG_W-1:0]        b_reg,
  input  logic [DATA_W-1:0]       b_data,
  input  logic                    rsv_valid,
  output logic                    rsv_ready,
  input  logic [REG_W-1:0]        rsv_reg,
  input  logic [REG_W-1:0]        chk_reg1,
  input  logic [REG_W-1:0]        chk_reg2,
  output logic                    chk_busy1,
  output logic                    chk_busy2,
  output logic                    RegWrite,
  output logic [REG_W-1:0]        Write_register,
  output logic [DATA_W-1:0]       Write_data,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int               SW         = $clog2(STARVE + 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // ---------------------------------------------------------------- FIFO
  logic    full;
  logic    empty;
  logic    push;
  logic    pop;
  wb_req_t push_req;
  wb_req_t head;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // ---------------------------------------------------------- arbitration
  logic [SW-1:0] starve_q, starve_d;
  logic          a_acc;
  logic          b_acc;
  logic          starved;

  // A wins by default; B wins once it has been blocked STARVE cycles.
  assign starved = (starve_q >= STARVE_LIM);
  assign a_ready = !full && (!starved || !b_valid);
  assign b_ready = !full && (!a_valid || starved);
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready && !a_acc;

  always_comb begin
    push_req = a_acc ? '{rd: a_reg, data: a_data} : '{rd: b_reg, data: b_data};
  end

  assign push = (a_acc || b_acc) && !is_zero_reg(push_req.rd);
  assign pop  = !empty;

  // Only blocking by A counts toward starvation; waiting on a full FIFO
  // holds the count.
  always_comb begin
    starve_d = starve_q;
    if (!b_valid || b_acc) begin
      starve_d = '0;
    end else if (!b_ready && !full && !starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // ----------------------------------------------------------- scoreboard
  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [NREGS-1:0] inc_vec;
  logic [NREGS-1:0] dec_vec;
  logic             rsv_inc;

  assign rsv_ready = is_zero_reg(rsv_reg) || (cnt_q[rsv_reg] != CNT_MAX);
  assign rsv_inc   = rsv_valid && rsv_ready && !is_zero_reg(rsv_reg);
  assign chk_busy1 = (cnt_q[chk_reg1] != '0);
  assign chk_busy2 = (cnt_q[chk_reg2] != '0);

  // Unreserved writes must not underflow, so the decrement is gated on a
  // non-zero count.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (rsv_inc) begin
      inc_vec[rsv_reg] = 1'b1;
    end
    if (pop && (cnt_q[head.rd] != '0)) begin
      dec_vec[head.rd] = 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  // ------------------------------------------------------- output stage
  logic              regwrite_q, regwrite_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    regwrite_d = pop;
    wreg_d     = pop ? head.rd   : wreg_q;
    wdata_d    = pop ? head.data : wdata_q;
  end

  assign RegWrite       = regwrite_q;
  assign Write_register = wreg_q;
  assign Write_data     = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule
